// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: assembles bits on BTU, extracts byte on DONE,
// checks parity/stop and holds RXRDY plus sticky error flags until host read.
module uart_rx_frame_ctrl #(
  parameter int FRAME_MAX = 11,
  parameter bit CHK_STOP  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic       btu,
  input  logic       done,
  input  logic       start,
  input  logic       rd_strb,
  output logic [7:0] rx_data,
  output logic       rxrdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf
);

  localparam int CW = $clog2(FRAME_MAX + 1);
  localparam logic [CW-1:0] FMAX = CW'(FRAME_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RECV,
    LOAD
  } state_t;

  state_t                 state;
  logic [FRAME_MAX-1:0]   sr;
  logic [CW-1:0]          bcnt;

  logic [CW-1:0]          fx;
  logic [FRAME_MAX-1:0]   a;
  logic [7:0]             data;
  logic                   pbit;
  logic                   sbit;
  logic                   parity_bad;
  logic                   stop_bad;

  // Frame is right-justified so a[0] is always the start bit
  always_comb begin
    fx         = CW'(9) + CW'(eight) + CW'(pen);
    a          = sr >> (FMAX - fx);
    data       = eight ? a[8:1] : {1'b0, a[7:1]};
    pbit       = a[fx - CW'(2)];
    sbit       = a[fx - CW'(1)];
    parity_bad = pen & (^data ^ pbit ^ ohel);
    stop_bad   = (CHK_STOP & ~sbit) | (bcnt != fx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      bcnt    <= '0;
      rx_data <= '0;
      rxrdy   <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (state == LOAD) begin
        rx_data <= data;
        rxrdy   <= 1'b1;
        perr    <= parity_bad;
        ferr    <= stop_bad;
        if (rxrdy && !rd_strb)
          ovf <= 1'b1;
      end else if (rd_strb) begin
        rxrdy <= 1'b0;
        perr  <= 1'b0;
        ferr  <= 1'b0;
        ovf   <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            sr    <= '0;
            bcnt  <= '0;
            state <= ARM;
          end
        end
        ARM: begin
          if (btu) begin
            sr    <= {rx, sr[FRAME_MAX-1:1]};
            bcnt  <= bcnt + CW'(1);
            state <= RECV;
          end else if (!start) begin
            state <= IDLE;
          end
        end
        RECV: begin
          // Extra bit-times beyond the register width are dropped
          if (btu && bcnt != FMAX) begin
            sr   <= {rx, sr[FRAME_MAX-1:1]};
            bcnt <= bcnt + CW'(1);
          end
          if (done)
            state <= LOAD;
        end
        LOAD: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
